// File: rtl/traffic_request_unit.sv
// -----------------------------------------------------------------------------
// traffic_request_unit
//
// Input stage for the traffic light FSM. Each of the five Nexys4DDR push
// buttons is synchronized, debounced and edge-detected. Every qualified press
// is held in a sticky request latch until the FSM acknowledges it.
//
// Optional feature (compile-time macro PRESS_COUNT_EN):
//   defined   -> a saturating CNT_W-bit press counter per lane, cleared by ack,
//                exported on press_count (lane i at [i*CNT_W +: CNT_W]).
//   undefined -> no press_count port and no counters.
//
// Parameters:
//   DB_TICKS  cycles an input must be stable before btn_level follows it (>= 2)
//   CNT_W     width of each press counter (PRESS_COUNT_EN only)
//
// Ports:
//   CLK100MHZ    in   1        system clock
//   CPU_RESETN   in   1        asynchronous active-low reset
//   BTN          in   5        raw buttons [0]=U ped A, [1]=D ped B,
//                              [2]=L car A, [3]=R car B, [4]=C emergency
//   ack          in   5        per-lane clear strobe from the traffic light FSM
//   req          out  5        pending (latched) requests
//   press_pulse  out  5        one-cycle pulse per debounced rising edge
//   btn_level    out  5        debounced button levels
//   press_count  out  5*CNT_W  per-lane press counts (PRESS_COUNT_EN only)
//
// Request handshake: a lane's request is raised by the same clock edge that
// registers its press_pulse and stays high until the FSM samples ack high on
// that lane at a later edge. A press arriving at the same edge as an ack wins,
// so the FSM never loses a request it has not seen yet. ack on an idle lane is
// ignored. All outputs are registered; no input reaches an output
// combinationally.
// -----------------------------------------------------------------------------
module traffic_request_unit #(
  parameter int DB_TICKS = 1_000_000,
  parameter int CNT_W    = 4
) (
  input  logic                 CLK100MHZ,
  input  logic                 CPU_RESETN,
  input  logic [4:0]           BTN,
  input  logic [4:0]           ack,
  output logic [4:0]           req,
  output logic [4:0]           press_pulse,
  output logic [4:0]           btn_level
`ifdef PRESS_COUNT_EN
  ,
  output logic [5*CNT_W-1:0]   press_count
`endif
);

  localparam int              DB_W   = $clog2(DB_TICKS);
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DB_TICKS - 1);

  logic [4:0]      s1;
  logic [4:0]      s2;
  logic [4:0]      level_d;
  logic [DB_W-1:0] db_cnt [5];
  logic [4:0]      rise;

  // Rising edge of the debounced level; drives both the pulse and the latch
  // so that req and press_pulse appear at the same edge.
  assign rise = btn_level & ~level_d;

  // Two-flop synchronizer, nothing between the stages.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= BTN;
      s2 <= s1;
    end
  end

  // Debouncer: the counter only runs while the synchronized input disagrees
  // with the debounced level, so any glitch shorter than DB_TICKS cycles
  // clears it and restarts qualification.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      btn_level <= '0;
      for (int i = 0; i < 5; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (s2[i] == btn_level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_MAX) begin
          btn_level[i] <= s2[i];
          db_cnt[i]    <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // Edge detector and sticky request latch (set beats clear).
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      level_d     <= '0;
      press_pulse <= '0;
      req         <= '0;
    end else begin
      level_d     <= btn_level;
      press_pulse <= rise;
      req         <= rise | (req & ~ack);
    end
  end

`ifdef PRESS_COUNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Saturating per-lane press counter. A press coincident with an ack counts
  // as the first press after the clear.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      press_count <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (rise[i]) begin
          if (ack[i]) begin
            press_count[i*CNT_W +: CNT_W] <= CNT_W'(1);
          end else if (press_count[i*CNT_W +: CNT_W] != CNT_MAX) begin
            press_count[i*CNT_W +: CNT_W] <= press_count[i*CNT_W +: CNT_W] + CNT_W'(1);
          end
        end else if (ack[i]) begin
          press_count[i*CNT_W +: CNT_W] <= '0;
        end
      end
    end
  end
`else
  // Press counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_traffic_request_unit.sv
// -----------------------------------------------------------------------------
// tb_traffic_request_unit
//
// Self-checking bench for traffic_request_unit with DB_TICKS=4, CNT_W=4.
// Compile with +define+PRESS_COUNT_EN to also exercise the press counters.
// Every qualified press the drivers create pushes its expected pulse vector
// onto exp_q; a monitor pops and compares whenever press_pulse is non-zero.
// -----------------------------------------------------------------------------
module tb_traffic_request_unit;

  localparam int DB_TICKS = 4;
  localparam int CNT_W    = 4;

  logic       CLK100MHZ;
  logic       CPU_RESETN;
  logic [4:0] BTN;
  logic [4:0] ack;
  logic [4:0] req;
  logic [4:0] press_pulse;
  logic [4:0] btn_level;
`ifdef PRESS_COUNT_EN
  logic [5*CNT_W-1:0] press_count;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [4:0] exp_q[$];

  traffic_request_unit #(
    .DB_TICKS (DB_TICKS),
    .CNT_W    (CNT_W)
  ) dut (
    .CLK100MHZ   (CLK100MHZ),
    .CPU_RESETN  (CPU_RESETN),
    .BTN         (BTN),
    .ack         (ack),
    .req         (req),
    .press_pulse (press_pulse),
    .btn_level   (btn_level)
`ifdef PRESS_COUNT_EN
    ,
    .press_count (press_count)
`endif
  );

  // ---------------- clock / reset ----------------
  initial CLK100MHZ = 1'b0;
  always #5 CLK100MHZ = ~CLK100MHZ;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every non-zero pulse vector must match the next
  // expected press, sampled on the falling edge.
  always @(negedge CLK100MHZ) begin
    if (CPU_RESETN && press_pulse != 5'b0) begin
      if (exp_q.size() == 0) begin
        check("pulse_unexpected", 32'(press_pulse), 32'd0);
      end else begin
        check("pulse_sb", 32'(press_pulse), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- drivers ----------------
  // Advance n active edges and land 1 ns after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge CLK100MHZ);
    #1;
  endtask

  // Qualified press: hold long enough to qualify, then release long enough
  // for the release to qualify as well.
  task automatic press(input logic [4:0] mask);
    BTN = BTN | mask;
    exp_q.push_back(mask);
    step(8);
    BTN = BTN & ~mask;
    step(10);
  endtask

  task automatic pulse_ack(input logic [4:0] mask);
    ack = mask;
    step(1);
    ack = 5'b0;
  endtask

`ifdef PRESS_COUNT_EN
  function automatic logic [CNT_W-1:0] lane_cnt(input int lane);
    return press_count[lane*CNT_W +: CNT_W];
  endfunction
`endif

  // ---------------- stimulus ----------------
  initial begin
    CPU_RESETN = 1'b0;
    BTN        = 5'b0;
    ack        = 5'b0;
    step(3);
    check("reset_req", 32'(req), 32'd0);
    check("reset_pulse", 32'(press_pulse), 32'd0);
    check("reset_level", 32'(btn_level), 32'd0);
    @(negedge CLK100MHZ);
    CPU_RESETN = 1'b1;
    step(2);

    // Basic latency on lane 0: raised just after edge 0.
    BTN[0] = 1'b1;
    exp_q.push_back(5'b00001);
    for (int k = 1; k <= 20; k++) begin
      step(1);
      check($sformatf("lat_level_e%0d", k), 32'(btn_level[0]), 32'(k >= 6));
      check($sformatf("lat_pulse_e%0d", k), 32'(press_pulse[0]), 32'(k == 7));
      check($sformatf("lat_req_e%0d", k), 32'(req[0]), 32'(k >= 7));
    end
    BTN[0] = 1'b0;
    step(10);
    check("release_no_pulse_req", 32'(req), 32'b00001);

    // Short glitch on lane 2 must not qualify.
    BTN[2] = 1'b1;
    step(3);
    BTN[2] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step(1);
      check("glitch_lane2", 32'({btn_level[2], press_pulse[2], req[2]}), 32'd0);
    end

    // ack on lane 1, then ack on an idle lane.
    press(5'b00010);
    check("ack_pre", 32'(req), 32'b00011);
    pulse_ack(5'b00010);
    check("ack_clear", 32'(req), 32'b00001);
    pulse_ack(5'b00010);
    check("ack_idle", 32'(req), 32'b00001);
    pulse_ack(5'b00001);
    check("ack_lane0", 32'(req), 32'd0);

    // ack coincident with the edge that raises the lane-3 press.
    BTN[3] = 1'b1;
    exp_q.push_back(5'b01000);
    step(6);
    check("coinc_level", 32'(btn_level[3]), 32'd1);
    check("coinc_req_before", 32'(req[3]), 32'd0);
    pulse_ack(5'b01000);
    check("coinc_req", 32'(req[3]), 32'd1);
    check("coinc_pulse", 32'(press_pulse[3]), 32'd1);
`ifdef PRESS_COUNT_EN
    check("coinc_count3", 32'(lane_cnt(3)), 32'd1);
`endif
    BTN[3] = 1'b0;
    step(10);
    pulse_ack(5'b01000);
    check("coinc_cleanup", 32'(req), 32'd0);

    // Random short glitches on random lanes.
    for (int g = 0; g < 4; g++) begin
      int lane;
      int len;
      lane = $urandom_range(0, 4);
      len  = $urandom_range(1, DB_TICKS - 1);
      BTN[lane] = 1'b1;
      step(len);
      BTN[lane] = 1'b0;
      step(8);
      check($sformatf("rand_glitch_l%0d_n%0d", lane, len), 32'({btn_level, req}), 32'd0);
    end

    // Simultaneous presses, then emergency held, then async reset.
    press(5'b00101);
    check("simul_req", 32'(req), 32'b00101);
    BTN[4] = 1'b1;
    exp_q.push_back(5'b10000);
    step(8);
    check("pre_reset_req", 32'(req), 32'b10101);
    #3;
    CPU_RESETN = 1'b0;
    #1;
    check("async_reset_outs", 32'({req, press_pulse, btn_level}), 32'd0);
`ifdef PRESS_COUNT_EN
    check("async_reset_count", 32'(press_count), 32'd0);
`endif
    step(2);
    #3;
    CPU_RESETN = 1'b1;
    exp_q.push_back(5'b10000);
    for (int j = 1; j <= 8; j++) begin
      step(1);
      check($sformatf("rerq_level_e%0d", j), 32'(btn_level[4]), 32'(j >= 6));
      check($sformatf("rerq_req_e%0d", j), 32'(req[4]), 32'(j >= 7));
    end
    BTN[4] = 1'b0;
    step(10);
    pulse_ack(5'b11111);
    check("post_reset_clear", 32'(req), 32'd0);

    // 17 presses on lane 0 without ack: req stays set, count saturates.
    for (int p = 1; p <= 17; p++) begin
      press(5'b00001);
      check($sformatf("multi_req_p%0d", p), 32'(req), 32'b00001);
`ifdef PRESS_COUNT_EN
      check($sformatf("sat_count_p%0d", p), 32'(lane_cnt(0)), 32'((p > 15) ? 15 : p));
`endif
    end
    pulse_ack(5'b00001);
    check("sat_ack_req", 32'(req), 32'd0);
`ifdef PRESS_COUNT_EN
    check("sat_ack_count", 32'(lane_cnt(0)), 32'd0);
`endif

    step(4);
    check("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
